// File: rtl/proc_loader.sv
// proc_loader: command-driven serial loader and run sequencer for the tiny
// processor. Host commands (ILOAD, DLOAD, RUN) are queued in a small FIFO.
// Each load is shifted out as a 12-bit frame {data, addr}, LSB first, under
// the matching chip select. Each RUN raises en until the processor reports
// done, so the program executes exactly once.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid_in      host command valid
//   cmd_ready_out     FIFO not full
//   cmd_kind_in       0=ILOAD 1=DLOAD 2=RUN 3=reserved (dropped)
//   cmd_addr_in       cache address for loads
//   cmd_data_in       cache data for loads
//   csi_out, csd_out  instruction / data chip selects, active low
//   mosi_out          serial data
//   en_out            processor run enable
//   done_in           processor done/idle flag
//   busy_out          FSM active or FIFO non-empty
//   run_done_out      one-cycle pulse after a RUN completes
//   timeout_out       sticky watchdog flag
//
// Optional feature: define PROC_LOADER_TIMEOUT_EN to enable the run watchdog
// (TIMEOUT cycles) and the ABORT state. Otherwise timeout_out is tied low.
module proc_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic [1:0] cmd_kind_in,
    input  logic [3:0] cmd_addr_in,
    input  logic [7:0] cmd_data_in,
    output logic       csi_out,
    output logic       csd_out,
    output logic       mosi_out,
    output logic       en_out,
    input  logic       done_in,
    output logic       busy_out,
    output logic       run_done_out,
    output logic       timeout_out
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] K_ILOAD = 2'd0;
    localparam logic [1:0] K_DLOAD = 2'd1;
    localparam logic [1:0] K_RUN   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_GAP, S_RUN_REQ, S_RUN_WAIT
`ifdef PROC_LOADER_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    state_t         state_q, state_d;
    cmd_t           mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    cmd_t           cur_q, cur_d;
    logic [3:0]     bit_q, bit_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           run_done_q, run_done_d;
    logic           push, pop;
    logic [11:0]    frame;

`ifdef PROC_LOADER_TIMEOUT_EN
    logic [7:0]     tmo_q, tmo_d;
    logic           timeout_q, timeout_d;
    logic           tmo_hit;
    assign tmo_hit     = (tmo_q == 8'(TIMEOUT));
    assign timeout_out = timeout_q;
`else
    logic [7:0]     unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_out    = 1'b0;
`endif

    assign cmd_ready_out = (count_q != CW'(FIFO_DEPTH));
    assign busy_out      = (state_q != S_IDLE) || (count_q != '0);
    assign run_done_out  = run_done_q;
    assign push          = cmd_valid_in && cmd_ready_out;
    assign frame         = {cur_q.data, cur_q.addr};

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        run_done_d = 1'b0;
        pop        = 1'b0;
        csi_out    = 1'b1;
        csd_out    = 1'b1;
        mosi_out   = 1'b0;
        en_out     = 1'b0;
`ifdef PROC_LOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    cur_d = mem_q[rd_ptr_q];
                    case (mem_q[rd_ptr_q].kind)
                        K_ILOAD, K_DLOAD: begin
                            state_d = S_SHIFT;
                            bit_d   = 4'd0;
                        end
                        K_RUN: begin
                            state_d = S_RUN_REQ;
`ifdef PROC_LOADER_TIMEOUT_EN
                            tmo_d     = 8'd0;
                            timeout_d = 1'b0;
`endif
                        end
                        default: ; // reserved kind: dropped on pop
                    endcase
                end
            end
            S_SHIFT: begin
                csi_out  = (cur_q.kind != K_ILOAD);
                csd_out  = (cur_q.kind != K_DLOAD);
                mosi_out = frame[bit_q];
                if (bit_q == 4'd11) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            S_RUN_REQ: begin
                en_out = 1'b1;
                if (!done_in) state_d = S_RUN_WAIT;
`ifdef PROC_LOADER_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
                if (tmo_hit) begin
                    en_out    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_ABORT;
                end
`endif
            end
            S_RUN_WAIT: begin
                // en drops combinationally with done so the processor never
                // sees en high while idle and cannot start a second pass.
                en_out = ~done_in;
                if (done_in) begin
                    state_d    = S_IDLE;
                    run_done_d = 1'b1;
                end
`ifdef PROC_LOADER_TIMEOUT_EN
                tmo_d = tmo_q + 8'd1;
                if (tmo_hit) begin
                    en_out     = 1'b0;
                    timeout_d  = 1'b1;
                    run_done_d = 1'b0;
                    state_d    = S_ABORT;
                end
`endif
            end
`ifdef PROC_LOADER_TIMEOUT_EN
            S_ABORT: begin
                if (done_in) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_kind_in, cmd_addr_in, cmd_data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            run_done_q <= 1'b0;
`ifdef PROC_LOADER_TIMEOUT_EN
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            run_done_q <= run_done_d;
`ifdef PROC_LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
`endif
        end
    end
endmodule

// File: tb/tb_proc_loader.sv
// Bench for proc_loader: table of host commands with their expected frames,
// a scoreboard queue of frames checked by a serial-line monitor, a small
// processor model on en/done, and hand sequences for full FIFO, reset
// mid-frame and (with PROC_LOADER_TIMEOUT_EN) the run watchdog.
module tb_proc_loader;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid_in = 1'b0;
    logic       cmd_ready_out;
    logic [1:0] cmd_kind_in = '0;
    logic [3:0] cmd_addr_in = '0;
    logic [7:0] cmd_data_in = '0;
    logic       csi_out, csd_out, mosi_out, en_out;
    logic       done_in;
    logic       busy_out, run_done_out, timeout_out;

    always #5 clk = ~clk;

    proc_loader #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_kind_in(cmd_kind_in), .cmd_addr_in(cmd_addr_in), .cmd_data_in(cmd_data_in),
        .csi_out(csi_out), .csd_out(csd_out), .mosi_out(mosi_out), .en_out(en_out),
        .done_in(done_in), .busy_out(busy_out), .run_done_out(run_done_out),
        .timeout_out(timeout_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Processor model: starts on en while idle, busy for run_len cycles.
    // In infinite mode it only stops once en has been withdrawn.
    int run_len  = 8;
    bit infinite = 1'b0;
    int busy_cnt = 0;
    int exec_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            done_in  <= 1'b1;
            busy_cnt <= 0;
        end else if (done_in) begin
            if (en_out) begin
                done_in  <= 1'b0;
                busy_cnt <= run_len;
                exec_cnt <= exec_cnt + 1;
            end
        end else if (infinite) begin
            if (!en_out) done_in <= 1'b1;
        end else if (busy_cnt <= 1) begin
            done_in <= 1'b1;
        end else begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Scoreboard of {kind, frame} expected on the serial lines.
    logic [13:0] exp_q[$];
    logic [13:0] e;
    logic [11:0] fr;
    logic [1:0]  fk;
    int bitn = 0, hi_run = 100, frames = 0, done_pulses = 0;
    logic done_prev = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            bitn      = 0;
            hi_run    = 100;
            done_prev = 1'b1;
        end else begin
            if (en_out) chk("cs_high_while_en", {30'd0, csi_out, csd_out}, 32'd3);
            if (done_in && !done_prev) chk("en_low_at_done_rise", {31'd0, en_out}, 32'd0);
            done_prev = done_in;
            if (run_done_out) done_pulses++;
            if (!csi_out || !csd_out) begin
                if (bitn == 0) begin
                    chk("gap_before_frame", {31'd0, hi_run >= GAP}, 32'd1);
                    chk("single_cs", {31'd0, csi_out ^ csd_out}, 32'd1);
                    fk = csi_out ? 2'd1 : 2'd0;
                end
                if (bitn < 12) fr[bitn] = mosi_out;
                bitn++;
                hi_run = 0;
            end else begin
                if (bitn != 0) begin
                    frames++;
                    chk("frame_len", bitn, 12);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_kind", {30'd0, fk}, {30'd0, e[13:12]});
                        chk("frame_bits", {20'd0, fr}, {20'd0, e[11:0]});
                    end
                    bitn = 0;
                end
                hi_run++;
            end
        end
    end

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  addr;
        logic [7:0]  data;
        bit          emit;
        logic [11:0] frame;
    } vec_t;
    vec_t tbl[8];

    task automatic push(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d,
                        input bit emit, input logic [11:0] ef, output bit acc);
        cmd_valid_in = 1'b1;
        cmd_kind_in  = k;
        cmd_addr_in  = a;
        cmd_data_in  = d;
        acc = cmd_ready_out;
        @(posedge clk);
        #1;
        cmd_valid_in = 1'b0;
        if (acc && emit) exp_q.push_back({k, ef});
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (busy_out && i < 3000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk(nm, {31'd0, busy_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int f0, p0, x0, en_cyc, i;

        tbl[0] = '{2'd0, 4'h5, 8'hA3, 1'b1, 12'hA35};
        tbl[1] = '{2'd1, 4'hF, 8'h80, 1'b1, 12'h80F};
        tbl[2] = '{2'd0, 4'h0, 8'hFF, 1'b1, 12'hFF0};
        tbl[3] = '{2'd1, 4'h3, 8'h00, 1'b1, 12'h003};
        tbl[4] = '{2'd3, 4'h7, 8'h55, 1'b0, 12'h000};
        tbl[5] = '{2'd0, 4'hA, 8'h5A, 1'b1, 12'h5AA};
        tbl[6] = '{2'd1, 4'h1, 8'h01, 1'b1, 12'h011};
        tbl[7] = '{2'd0, 4'h8, 8'h7E, 1'b1, 12'h7E8};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_csi", {31'd0, csi_out}, 32'd1);
        chk("rst_csd", {31'd0, csd_out}, 32'd1);
        chk("rst_mosi", {31'd0, mosi_out}, 32'd0);
        chk("rst_en", {31'd0, en_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_run_done", {31'd0, run_done_out}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_out}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready_out}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Push-to-chip-select latency: IDLE pop cycle, then frame starts.
        push(2'd0, 4'h2, 8'hC4, 1'b1, 12'hC42, acc);
        chk("pop_cycle_csi_high", {31'd0, csi_out}, 32'd1);
        @(posedge clk);
        #1;
        chk("first_shift_csi_low", {31'd0, csi_out}, 32'd0);
        wait_idle("idle_after_first");

        // Table: back-to-back pushes, reserved kind dropped.
        f0 = frames;
        for (int k = 0; k < 8; k++) begin
            push(tbl[k].kind, tbl[k].addr, tbl[k].data, tbl[k].emit, tbl[k].frame, acc);
            if (!acc) begin
                while (!cmd_ready_out) begin
                    @(posedge clk);
                    #1;
                end
                push(tbl[k].kind, tbl[k].addr, tbl[k].data, tbl[k].emit, tbl[k].frame, acc);
            end
        end
        wait_idle("idle_after_table");
        chk("table_frames", frames - f0, 7);
        chk("table_queue_empty", exp_q.size(), 0);

        // Single RUN: exactly one EXEC entry and one run_done pulse.
        run_len = 16;
        p0 = done_pulses;
        x0 = exec_cnt;
        push(2'd2, 4'h0, 8'h00, 1'b0, 12'h000, acc);
        @(posedge clk);
        #1;
        chk("run_en_after_pop", {31'd0, en_out}, 32'd1);
        wait_idle("idle_after_run");
        chk("run_exec_count", exec_cnt - x0, 1);
        chk("run_done_pulses", done_pulses - p0, 1);
        chk("run_en_low_idle", {31'd0, en_out}, 32'd0);

        // FIFO full: RUN holds the FSM while 5 loads are offered.
        run_len = 60;
        push(2'd2, 4'h0, 8'h00, 1'b0, 12'h000, acc);
        @(posedge clk);
        #1;
        f0 = frames;
        for (int k = 0; k < 5; k++) begin
            push(2'(k % 2), 4'(k), 8'(8'h10 + k), 1'b1, {8'(8'h10 + k), 4'(k)}, acc);
            if (k == 3) chk("full_ready_low", {31'd0, cmd_ready_out}, 32'd0);
            if (k == 4) chk("fifth_dropped", {31'd0, acc}, 32'd0);
        end
        wait_idle("idle_after_full");
        chk("full_frames", frames - f0, 4);
        chk("full_queue_empty", exp_q.size(), 0);

        // Reset at SHIFT cycle 6 with another command still queued.
        f0 = frames;
        push(2'd0, 4'h6, 8'h33, 1'b1, 12'h336, acc);
        push(2'd1, 4'h1, 8'h11, 1'b1, 12'h111, acc);
        i = 0;
        while (csi_out && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("csi_low_seen", {31'd0, csi_out}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_csi", {31'd0, csi_out}, 32'd1);
        chk("midrst_busy", {31'd0, busy_out}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready_out}, 32'd1);
        rst = 1'b0;
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_frames", frames - f0, 0);
        chk("midrst_still_idle", {31'd0, busy_out}, 32'd0);

`ifdef PROC_LOADER_TIMEOUT_EN
        // Watchdog: non-terminating program, en must drop after TMO cycles.
        infinite = 1'b1;
        p0 = done_pulses;
        en_cyc = 0;
        push(2'd2, 4'h0, 8'h00, 1'b0, 12'h000, acc);
        i = 0;
        while (i < 200) begin
            @(posedge clk);
            #1;
            i++;
            if (en_out) en_cyc++;
            else if (en_cyc > 0) break;
        end
        chk("tmo_en_cycles", en_cyc, TMO);
        chk("tmo_flag_set", {31'd0, timeout_out}, 32'd1);
        wait_idle("idle_after_abort");
        chk("tmo_no_run_done", done_pulses - p0, 0);
        chk("tmo_flag_sticky", {31'd0, timeout_out}, 32'd1);
        infinite = 1'b0;
        run_len  = 4;
        push(2'd2, 4'h0, 8'h00, 1'b0, 12'h000, acc);
        @(posedge clk);
        #1;
        chk("tmo_flag_cleared", {31'd0, timeout_out}, 32'd0);
        wait_idle("idle_after_rerun");
`else
        chk("timeout_tied_low", {31'd0, timeout_out}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/proc_loader.md
# proc_loader

Command-driven SPI-style master that sits directly upstream of the tiny processor and drives its `csi`/`csd`/`mosi`/`en` pins and watches its `done` pin. Queues host commands (instruction-load, data-load, run) in a small FIFO and serialises each load into the processor's 12-bit frame format. Sequences a run so the processor executes exactly once per RUN command. Shares `clk` and `rst` with the processor.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries, power of two, 2..16
- `GAP_CYCLES`, 2: chip-select-high cycles after each frame, ≥1
- `TIMEOUT`, 255: run watchdog limit in cycles, 8-bit; used only with `PROC_LOADER_TIMEOUT_EN`

- `clk` in 1: clock
- `rst` in 1: reset; one clock; reset is synchronous and active-high
- `cmd_valid_in` in 1: host command valid
- `cmd_ready_out` out 1: FIFO not full
- `cmd_kind_in` in 2: 0=ILOAD, 1=DLOAD, 2=RUN, 3=reserved
- `cmd_addr_in` in 4: cache address for loads
- `cmd_data_in` in 8: cache data for loads
- `csi_out` out 1: instruction chip select, active low
- `csd_out` out 1: data chip select, active low
- `mosi_out` out 1: serial data
- `en_out` out 1: processor run enable
- `done_in` in 1: processor done/idle flag
- `busy_out` out 1: FSM not in IDLE, or FIFO not empty
- `run_done_out` out 1: one-cycle pulse when a RUN completes
- `timeout_out` out 1: sticky watchdog flag, cleared when the next RUN starts

## Operation
- Push: `cmd_valid_in & cmd_ready_out` at an edge writes {kind, addr, data}. Pushes while full are ignored.
- FSM states: IDLE, SHIFT, GAP, RUN_REQ, RUN_WAIT, ABORT (ABORT exists only with the macro).
- IDLE with FIFO non-empty: pop the head entry.
  - ILOAD/DLOAD → SHIFT, bit counter = 0.
  - RUN → RUN_REQ.
  - Reserved kind → discarded; remain in IDLE.
- SHIFT:
  - Drive the selected chip select low: `csi_out` for ILOAD, `csd_out` for DLOAD.
  - `mosi_out` = frame[k] on cycle k, where frame = {data, addr}. Order is LSB first: addr[0..3], then data[0..7].
  - After cycle 11 → GAP.
- GAP:
  - Both chip selects high, `mosi_out` = 0, for `GAP_CYCLES` cycles, then → IDLE.
  - The processor commits the write in the first GAP cycle.
- RUN_REQ: `en_out` = 1. When `done_in` = 0 is sampled → RUN_WAIT.
- RUN_WAIT:
  - `en_out` = ~`done_in`, combinational. This ensures en is already low in the cycle done rises, so the processor cannot re-enter EXEC.
  - On `done_in` = 1 → IDLE and pulse `run_done_out`.
- `en_out` = 0 in every other state. Chip selects are never low while `en_out` = 1.
- Reset values: `csi_out` = `csd_out` = 1; `mosi_out` = `en_out` = 0; `busy_out` = `run_done_out` = `timeout_out` = 0; `cmd_ready_out` = 1; FIFO empty; FSM IDLE.
- Reset mid-frame or mid-run: all outputs return to reset values at the next edge and the FIFO is flushed. The processor is reset by the same `rst`, so a partial frame is never committed.

## Timing
- Push at edge N → pop at edge N+1 (if IDLE) → first chip-select-low cycle starts after edge N+1.
- One load occupies 12 + `GAP_CYCLES` cycles. Back-to-back loads have no extra idle cycle beyond one IDLE pop cycle.
- RUN: `en_out` rises the cycle after the pop. `done_in` falls 1 cycle later. `en_out` falls in the same cycle `done_in` rises.
- FIFO: simultaneous push and pop when non-full is allowed. Pointers wrap modulo `FIFO_DEPTH`. Full = count == `FIFO_DEPTH`.

## Configuration
- `PROC_LOADER_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering RUN_REQ and increments each cycle in RUN_REQ/RUN_WAIT.
  - On reaching `TIMEOUT`: `en_out` = 0, `timeout_out` set, → ABORT.
  - ABORT waits for `done_in` = 1, then → IDLE. No `run_done_out` pulse.
- Undefined: no counter, no ABORT state, `timeout_out` tied 0. A non-terminating program holds RUN_WAIT until `rst`.

## Test plan
- ILOAD addr=0x5, data=0xA3 → `csi_out` low exactly 12 cycles; `mosi_out` = 1,0,1,0,1,1,0,0,0,1,0,1; `csd_out` stays 1; processor icache[5] = 0xA3.
- DLOAD addr=0xF, data=0x80, then ILOAD → `csd_out` low for 12 cycles, then ≥2 cycles with both chip selects high before `csi_out` falls.
- Load a 16-entry program with no branches, then RUN → `en_out` high until `done_in` rises; `en_out` = 0 in that same cycle; one `run_done_out` pulse; no second EXEC entry.
- Push 5 commands with `FIFO_DEPTH` = 4 and no pop possible → `cmd_ready_out` = 0 after the 4th push; the 5th command is dropped; 4 frames are emitted.
- Assert `rst` at SHIFT cycle 6 → next cycle `csi_out` = 1, `busy_out` = 0, FIFO empty; processor icache unchanged.
- With macro, `TIMEOUT` = 20, and a `bnez` infinite loop → `en_out` drops 20 cycles after RUN_REQ entry; `timeout_out` = 1; return to IDLE after `done_in` = 1.
